// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared constants and types for the PS/2 scancode receive path.
// Prefix bytes, frame FSM encodings and the decoded record layout.
package ps2_scancode_receiver_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_record_t;

  // Odd parity across data and parity bit, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_scancode_receiver_frame_rx.sv
// PS/2 line synchronizer, falling-edge detect, 11-bit frame deframer and
// inactivity timeout. Emits the byte with one-cycle good/error/abort strobes.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_frame_rx
  import ps2_scancode_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_good,
  output logic       o_error,
  output logic       o_abort
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic          r_fall;
  logic          r_bit;
  ps2_state_e    r_state;
  ps2_state_e    w_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          w_tmo_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev <= r_clk_sync[1];
      r_fall     <= r_clk_prev & ~r_clk_sync[1];
      r_bit      <= r_dat_sync[1];
    end
  end

  // A falling edge on the same cycle as the terminal count wins over the timeout.
  assign w_tmo_hit = (r_state != ST_IDLE) && !r_fall && (r_tmo == TMO_LAST);
  assign o_byte    = r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_good  = 1'b0;
    o_error = 1'b0;
    o_abort = 1'b0;
    if (w_tmo_hit) begin
      w_next  = ST_IDLE;
      o_abort = 1'b1;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE:   if (!r_bit) w_next = ST_DATA;
        ST_DATA:   if (r_bitcnt == 3'd7) w_next = ST_PARITY;
        ST_PARITY: w_next = ST_STOP;
        ST_STOP: begin
          w_next = ST_IDLE;
          if (frame_ok(r_shift, r_par, r_bit)) o_good = 1'b1;
          else o_error = 1'b1;
        end
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (r_state == ST_IDLE || r_fall) r_tmo <= '0;
      else r_tmo <= r_tmo + TW'(1);
      if (r_fall) begin
        case (r_state)
          ST_IDLE: r_bitcnt <= 3'd0;
          ST_DATA: begin
            r_shift  <= {r_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          ST_PARITY: r_par <= r_bit;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver top: folds E0/F0 prefixes into flags and presents
// decoded scancode records through a one-entry valid/ack holding register.
module ps2_scancode_receiver
  import ps2_scancode_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  input  logic       iAck,
  output logic [7:0] oScanCode,
  output logic       oExtended,
  output logic       oBreak,
  output logic       oValid,
  output logic       oParityError,
  output logic       oOverrun
);

  logic [7:0]  w_byte;
  logic        w_good;
  logic        w_error;
  logic        w_abort;
  logic        w_is_prefix;
  logic        w_rec_vld;
  logic        r_pend_ext;
  logic        r_pend_brk;
  ps2_record_t r_rec;
  logic        r_valid;
  logic        r_perr;
  logic        r_ovr;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_ps2_clk  (iPS2Clk),
    .i_ps2_data (iPS2Data),
    .o_byte     (w_byte),
    .o_good     (w_good),
    .o_error    (w_error),
    .o_abort    (w_abort)
  );

  assign w_is_prefix = (w_byte == PS2_EXT_PREFIX) || (w_byte == PS2_BRK_PREFIX);
  assign w_rec_vld   = w_good && !w_is_prefix;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pend_ext <= 1'b0;
      r_pend_brk <= 1'b0;
      r_rec      <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_perr <= w_error;
      r_ovr  <= 1'b0;
      if (w_error || w_abort) begin
        r_pend_ext <= 1'b0;
        r_pend_brk <= 1'b0;
      end else if (w_good) begin
        if (w_byte == PS2_EXT_PREFIX) begin
          r_pend_ext <= 1'b1;
        end else if (w_byte == PS2_BRK_PREFIX) begin
          r_pend_brk <= 1'b1;
        end else begin
          r_pend_ext <= 1'b0;
          r_pend_brk <= 1'b0;
        end
      end
      // An ack in the same cycle frees the slot for the arriving record.
      if (w_rec_vld) begin
        if (!r_valid || iAck) begin
          r_rec   <= '{code: w_byte, brk: r_pend_brk, ext: r_pend_ext};
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && iAck) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign oScanCode    = r_rec.code;
  assign oBreak       = r_rec.brk;
  assign oExtended    = r_rec.ext;
  assign oValid       = r_valid;
  assign oParityError = r_perr;
  assign oOverrun     = r_ovr;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for ps2_scancode_receiver: directed PS/2 frames push
// expected records; a monitor pops and compares each record the DUT presents.
module tb_ps2_scancode_receiver;

  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iPS2Clk = 1'b1;
  logic       iPS2Data = 1'b1;
  logic       iAck = 1'b0;
  logic [7:0] oScanCode;
  logic       oExtended;
  logic       oBreak;
  logic       oValid;
  logic       oParityError;
  logic       oOverrun;

  ps2_scancode_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPS2Clk      (iPS2Clk),
    .iPS2Data     (iPS2Data),
    .iAck         (iAck),
    .oScanCode    (oScanCode),
    .oExtended    (oExtended),
    .oBreak       (oBreak),
    .oValid       (oValid),
    .oParityError (oParityError),
    .oOverrun     (oOverrun)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int exp_perr = 0;
  int exp_ovr = 0;
  int seen_perr = 0;
  int seen_ovr = 0;
  bit auto_ack = 1'b0;
  bit ack_on_stop = 1'b0;
  bit chk_lat = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_rec(input logic [7:0] code, input logic brk, input logic ext);
    exp_q.push_back({code, brk, ext});
  endtask

  // One PS/2 bit: data settles, clock falls on a system negedge, then rises.
  task automatic ps2_bit(input logic b, input bit last);
    @(negedge Clock);
    iPS2Data = b;
    repeat (HALF) @(negedge Clock);
    iPS2Clk = 1'b0;
    repeat (3) @(negedge Clock);
    if (last && chk_lat) check("latency_cycle3_valid", 32'(oValid), 32'd0);
    if (last && ack_on_stop) iAck = 1'b1;
    @(negedge Clock);
    if (last && ack_on_stop) iAck = 1'b0;
    if (last && chk_lat) check("latency_cycle4_valid", 32'(oValid), 32'd1);
    repeat (HALF - 4) @(negedge Clock);
    iPS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    logic p;
    p = ~(^d) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(1'b1, 1'b1);
    repeat (HALF) @(negedge Clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code"}, 32'(oScanCode), 32'h00);
    check({tag, "_ext"},  32'(oExtended), 32'd0);
    check({tag, "_brk"},  32'(oBreak), 32'd0);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_perr"}, 32'(oParityError), 32'd0);
    check({tag, "_ovr"},  32'(oOverrun), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (auto_ack) iAck = oValid;
    end
  end

  // A record is new when valid rises, or valid stays high across an ack.
  initial begin
    logic       prev_v;
    logic [9:0] exp;
    prev_v = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      if (oParityError) seen_perr++;
      if (oOverrun) seen_ovr++;
      if (oValid && (!prev_v || iAck)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record actual=%0h required=none", {oScanCode, oBreak, oExtended});
        end else begin
          exp = exp_q.pop_front();
          check("record", 32'({oScanCode, oBreak, oExtended}), 32'(exp));
        end
      end
      prev_v = oValid;
    end
  end

  initial begin
    repeat (5) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    // Make code with latency check, then ack clears valid.
    push_rec(8'h1C, 1'b0, 1'b0);
    chk_lat = 1'b1;
    send_frame(8'h1C, 1'b0);
    chk_lat = 1'b0;
    iAck = 1'b1;
    @(negedge Clock);
    iAck = 1'b0;
    check("ack_clears_valid", 32'(oValid), 32'd0);
    check("ack_holds_code", 32'(oScanCode), 32'h1C);

    // Extended break: E0 F0 75.
    auto_ack = 1'b1;
    push_rec(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);

    // Bad parity clears a pending E0; then F0 1C.
    send_frame(8'hE0, 1'b0);
    exp_perr++;
    send_frame(8'h1C, 1'b1);
    check("parity_error_pulses", 32'(seen_perr), 32'(exp_perr));
    push_rec(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Overrun, then ack on the completion cycle of the next record.
    auto_ack = 1'b0;
    @(negedge Clock);
    iAck = 1'b0;
    push_rec(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0);
    exp_ovr++;
    send_frame(8'h1E, 1'b0);
    check("overrun_held_code", 32'(oScanCode), 32'h16);
    check("overrun_held_valid", 32'(oValid), 32'd1);
    check("overrun_pulses", 32'(seen_ovr), 32'(exp_ovr));
    push_rec(8'h1E, 1'b0, 1'b0);
    ack_on_stop = 1'b1;
    send_frame(8'h1E, 1'b0);
    ack_on_stop = 1'b0;
    check("ack_load_code", 32'(oScanCode), 32'h1E);
    check("ack_load_valid", 32'(oValid), 32'd1);
    check("ack_load_no_overrun", 32'(seen_ovr), 32'(exp_ovr));
    auto_ack = 1'b1;

    // Timeout abandons a partial frame and a pending F0.
    send_frame(8'hF0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    repeat (TMO + 20) @(negedge Clock);
    check("timeout_no_valid", 32'(oValid), 32'd0);
    check("timeout_no_error", 32'(seen_perr), 32'(exp_perr));
    push_rec(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0);

    // Reset mid-frame: held record and pending F0 are discarded.
    auto_ack = 1'b0;
    @(negedge Clock);
    iAck = 1'b0;
    send_frame(8'hE0, 1'b0);
    push_rec(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hF0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_all_zero("midreset");
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) ps2_bit(1'b1, 1'b0);
    repeat (HALF) @(negedge Clock);
    check("post_reset_no_valid", 32'(oValid), 32'd0);
    check("post_reset_no_error", 32'(seen_perr), 32'(exp_perr));
    auto_ack = 1'b1;
    push_rec(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    repeat (50) @(negedge Clock);
    check("records_outstanding", 32'(exp_q.size()), 32'd0);
    check("total_parity_errors", 32'(seen_perr), 32'(exp_perr));
    check("total_overruns", 32'(seen_ovr), 32'(exp_ovr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Upstream input stage for the MiniAlu keyboard path. Samples the external PS/2 clock/data lines, deframes 11-bit device-to-host frames, validates parity and stop bit, and folds the `E0` (extended) and `F0` (break) prefixes into flags on a single decoded scancode record. Records are presented to the CPU side through a one-entry valid/ack holding register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: `Clock` cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- `Clock`, in, 1: system clock. Single clock domain.
- `Reset`, in, 1: synchronous, active-high reset.
- `iPS2Clk`, in, 1: raw PS/2 clock line (asynchronous, idle high).
- `iPS2Data`, in, 1: raw PS/2 data line (asynchronous, idle high).
- `iAck`, in, 1: consumer accepts the current record; sampled only while `oValid`=1.
- `oScanCode`, out, 8: scancode byte, with prefixes stripped.
- `oExtended`, out, 1: an `E0` prefix preceded this code.
- `oBreak`, out, 1: an `F0` prefix preceded this code (key release).
- `oValid`, out, 1: record in `oScanCode`/`oExtended`/`oBreak` is valid.
- `oParityError`, out, 1: one-cycle pulse for a frame rejected on parity or stop bit.
- `oOverrun`, out, 1: one-cycle pulse when a completed record is dropped because the holding register is full.

## Operation
- **Synchronizer:** each of `iPS2Clk` and `iPS2Data` passes through a 2-FF synchronizer.
- **Edge detect:** a falling edge is synced clock previous=1, current=0. All frame bits are sampled from the synced data on that cycle.
- **Frame FSM:** states `IDLE`, `DATA`, `PARITY`, `STOP`.
  - `IDLE`: on an edge with data=0 (start bit), go to `DATA` and set bit count to 0. On an edge with data=1, stay in `IDLE`.
  - `DATA`: shift in LSB first, with new bit into MSB and shift right. After the 8th bit, go to `PARITY`.
  - `PARITY`: capture the bit, then go to `STOP`.
  - `STOP`: on the edge, the frame is good iff XOR(8 data bits, parity)=1 (odd parity) and stop bit=1. Always return to `IDLE`.
- **Bad frame:** pulse `oParityError`, discard the byte, and clear both prefix flags.
- **Timeout:** a counter clears on every falling edge and increments otherwise, only while not in `IDLE`. At `TIMEOUT_CYCLES-1` the FSM goes to `IDLE`, the partial byte is discarded, prefix flags are cleared, and no error pulse is raised.
- **Prefix decode, on a good byte:**
  - `8'hE0`: set the pending-extended flag; no record.
  - `8'hF0`: set the pending-break flag; no record.
  - Any other value: form the record {byte, pending-break, pending-extended}, then clear both pending flags.
- **Holding register:**
  - A record loads when `oValid`=0, or when `oValid`=1 and `iAck`=1 in the same cycle. `oValid` then stays/becomes 1.
  - A record arriving while `oValid`=1 and `iAck`=0 is dropped, `oOverrun` pulses, and the held record is unchanged.
  - `iAck` with no new record: `oValid`=0 next cycle; data outputs hold their last value.
  - `iAck` while `oValid`=0 is ignored.
- **Reset (any cycle, including mid-frame):** FSM to `IDLE`, counters, shift register, pending flags, synchronizers (to 1) and all outputs cleared. Outputs reset to 0: `oScanCode`=8'h00 and `oExtended`, `oBreak`, `oValid`, `oParityError`, `oOverrun` all 0.

## Timing
- Pin falling edge to edge-detect pulse: 3 `Clock` cycles (2 sync + 1 edge register).
- `oValid` rises on the cycle after the STOP-bit edge pulse. Same for `oParityError` and `oOverrun`.
- Minimum PS/2 bit period is 60 µs, far above 3 cycles, so no back-pressure is applied to the device.
- All outputs are registered. No combinational path exists from `iAck` to outputs.

## Structure
- Constants go in the shared definitions header:
  - `PS2_EXT_PREFIX` = 8'hE0
  - `PS2_BRK_PREFIX` = 8'hF0
  - FSM state encodings (2 bits)
- Sub-module `ps2_frame_rx`: synchronizer, edge detect, frame FSM and timeout. Outputs a byte, a one-cycle good strobe and an error strobe.
- The top level holds the prefix decode and the holding register.

## Test plan
- **Make code:** frame 8'h1C (parity 0) → `oValid`=1, `oScanCode`=8'h1C, `oBreak`=0, `oExtended`=0, 4 cycles after the stop edge at the pins; `iAck` → `oValid`=0 next cycle.
- **Extended break:** frames E0, F0, 75 → exactly one record {8'h75, brk=1, ext=1}; no record for the prefixes.
- **Parity error:** frame 8'h1C with parity 1 → `oParityError` one-cycle pulse, no `oValid`. A following F0 then 1C → {1C, brk=1, ext=0}.
- **Overrun:** two good frames 8'h16 then 8'h1E with no `iAck` → held record stays 8'h16, one `oOverrun` pulse. Ack on the completion cycle of 8'h1E → 8'h1E loads, `oValid` stays 1.
- **Timeout:** start bit plus 4 data bits, then idle `TIMEOUT_CYCLES` → FSM in `IDLE`, no outputs. A following full frame 8'h29 decodes correctly.
- **Reset mid-frame:** assert `Reset` after 5 bits → all outputs 0 next cycle. The remaining bits are ignored until a new start bit.
